// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer in front of a single-ported 16-bit memory.
// Port A is instruction fetch (read-only, program region); port B is
// load/store. One access in flight at a time: IDLE -> ISSUE -> RESP.
module mem_port_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [15:0]       a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_region,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [15:0]       b_wdata,
    output logic              b_ack,
    output logic [15:0]       b_rdata,
    output logic              mem_e,
    output logic              mem_we,
    output logic              mem_region,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_b_q, last_b_d;     // 1 = port B was granted last
    logic              port_b_q, port_b_d;     // port owning the access in flight
    logic              is_read_q, is_read_d;   // access returns data to its port
    logic              mem_e_q, mem_e_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_region_q, mem_region_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic [15:0]       a_rdata_q, a_rdata_d;
    logic [15:0]       b_rdata_q, b_rdata_d;
    logic              grant_b;
    logic              resp_live;

    // B wins when alone, on any tie in fixed-priority mode, or on a tie when A was served last
    assign grant_b = b_req && (!a_req || !ROUND_ROBIN || !last_b_q);

    // Next-state logic: the memory-side registers are loaded only on the
    // IDLE->ISSUE transition, so they read zero outside ISSUE.
    always_comb begin
        state_d      = state_q;
        last_b_d     = last_b_q;
        port_b_d     = port_b_q;
        is_read_d    = is_read_q;
        mem_e_d      = 1'b0;
        mem_we_d     = 1'b0;
        mem_region_d = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    state_d  = ST_ISSUE;
                    port_b_d = grant_b;
                    last_b_d = grant_b;
                    mem_e_d  = 1'b1;
                    if (grant_b) begin
                        mem_we_d     = b_we;
                        mem_region_d = b_region;
                        mem_addr_d   = b_addr;
                        mem_wdata_d  = b_wdata;
                        is_read_d    = !b_we;
                    end else begin
                        mem_addr_d   = a_addr;
                        is_read_d    = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (is_read_q) begin
                    if (port_b_q) begin
                        b_rdata_d = mem_rdata;
                    end else begin
                        a_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and command registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_b_q     <= 1'b1;
            port_b_q     <= 1'b0;
            is_read_q    <= 1'b0;
            mem_e_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_region_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_b_q     <= last_b_d;
            port_b_q     <= port_b_d;
            is_read_q    <= is_read_d;
            mem_e_q      <= mem_e_d;
            mem_we_q     <= mem_we_d;
            mem_region_q <= mem_region_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    // A reset arriving during RESP suppresses the ack in that same cycle
    assign resp_live = (state_q == ST_RESP) && !rst;

    assign a_ack   = resp_live && !port_b_q;
    assign b_ack   = resp_live && port_b_q;
    // Read data is bypassed from the memory in the ack cycle, held afterwards
    assign a_rdata = (a_ack && is_read_q) ? mem_rdata : a_rdata_q;
    assign b_rdata = (b_ack && is_read_q) ? mem_rdata : b_rdata_q;

    assign mem_e      = mem_e_q;
    assign mem_we     = mem_we_q && mem_e_q;
    assign mem_region = mem_region_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps followed by random traffic
// checked against a transaction-level arbitration and memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        tb_init;
    logic        a_req, b_req, b_we, b_region;
    logic [15:0] a_addr, b_addr, b_wdata;
    logic        a_ack, b_ack, mem_e, mem_we, mem_region, busy;
    logic [15:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        f_a_ack, f_b_ack, f_mem_e, f_mem_we, f_mem_region, f_busy;
    logic [15:0] f_a_rdata, f_b_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] env_mem [0:511];
    logic [15:0] ref_mem [0:511];
    logic        last_b;
    logic [15:0] held_a, held_b;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ROUND_ROBIN(1'b1), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_region(b_region), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_e(mem_e), .mem_we(mem_we), .mem_region(mem_region),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_port_arbiter #(.ROUND_ROBIN(1'b0), .ADDR_W(16)) dut_fp (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_ack(f_a_ack), .a_rdata(f_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_region(b_region), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_ack(f_b_ack), .b_rdata(f_b_rdata),
        .mem_e(f_mem_e), .mem_we(f_mem_we), .mem_region(f_mem_region),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata),
        .busy(f_busy)
    );

    function automatic logic [15:0] pat(input int i);
        return 16'((i * 32'h0101) ^ 32'h5A3C);
    endfunction

    function automatic int key(input logic region, input logic [15:0] addr);
        return int'({region, addr[7:0]});
    endfunction

    // Memory with one-cycle registered read
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 512; i++) env_mem[i] <= pat(i);
            mem_rdata <= 16'h0000;
        end else if (mem_e) begin
            if (mem_we) env_mem[key(mem_region, mem_addr)] <= mem_wdata;
            else        mem_rdata <= env_mem[key(mem_region, mem_addr)];
        end
    end

    // Stand-in memory for the fixed-priority instance (its data is not checked)
    always @(posedge clk) begin
        if (tb_init)      f_mem_rdata <= 16'h0000;
        else if (f_mem_e) f_mem_rdata <= f_mem_addr;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit ra, rb, first_b, exp_a, exp_b;
        int n_cyc, mode;

        for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
        tb_init = 1'b1; rst = 1'b1;
        a_req = 0; b_req = 0; b_we = 0; b_region = 0;
        a_addr = 0; b_addr = 0; b_wdata = 0;
        last_b = 1'b1; held_a = 0; held_b = 0;
        repeat (3) cyc();
        tb_init = 1'b0;

        // Reset values
        chk("rst_acks", {a_ack, b_ack}, 2'b00);
        chk("rst_mem", {mem_e, mem_we, mem_region, mem_addr, mem_wdata}, 35'h0);
        chk("rst_rdata", {a_rdata, b_rdata}, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fp", {f_a_ack, f_b_ack, f_mem_e, f_mem_we, f_mem_region, f_busy,
                       f_mem_addr, f_mem_wdata}, 38'h0);
        chk("rst_fp_rdata", {f_a_rdata, f_b_rdata}, 32'h0);
        rst = 1'b0;
        cyc();
        chk("idle_busy", busy, 1'b0);

        // Single fetch from 0x0004
        a_req = 1; a_addr = 16'h0004;
        cyc();
        chk("fetch_issue_mem", {mem_e, mem_we, mem_region, mem_addr}, {3'b100, 16'h0004});
        chk("fetch_issue_busy_ack", {busy, a_ack, b_ack}, 3'b100);
        cyc();
        chk("fetch_resp_ack", {a_ack, b_ack, mem_e}, 3'b100);
        chk("fetch_rdata", a_rdata, ref_mem[key(0, 16'h0004)]);
        held_a = ref_mem[key(0, 16'h0004)];
        a_req = 0; last_b = 0;
        cyc();
        chk("fetch_after", {busy, a_ack}, 2'b00);
        chk("fetch_held", a_rdata, held_a);

        // Store 0xBEEF to data 0x0010, then load it back
        b_req = 1; b_we = 1; b_region = 1; b_addr = 16'h0010; b_wdata = 16'hBEEF;
        cyc();
        chk("store_issue", {mem_e, mem_we, mem_region, mem_addr, mem_wdata},
            {3'b111, 16'h0010, 16'hBEEF});
        cyc();
        chk("store_ack", {a_ack, b_ack}, 2'b01);
        ref_mem[key(1, 16'h0010)] = 16'hBEEF;
        b_req = 0; last_b = 1;
        cyc();
        b_req = 1; b_we = 0; b_wdata = 16'h0000;
        cyc();
        chk("load_issue_we", {mem_e, mem_we}, 2'b10);
        cyc();
        chk("load_ack", {a_ack, b_ack}, 2'b01);
        chk("load_rdata", b_rdata, 16'hBEEF);
        held_b = 16'hBEEF;
        b_req = 0;
        cyc();
        chk("load_held", b_rdata, held_b);

        // Reset during RESP aborts the access; the re-held request completes
        a_req = 1; a_addr = 16'h0022;
        cyc();
        cyc();
        rst = 1;
        #1;
        chk("rst_resp_no_ack", {a_ack, b_ack}, 2'b00);
        cyc();
        chk("rst_resp_outs", {busy, mem_e, mem_we, mem_addr, a_rdata, b_rdata}, 51'h0);
        rst = 0; last_b = 1; held_a = 0; held_b = 0;
        cyc();
        chk("rerun_issue", {mem_e, mem_addr}, {1'b1, 16'h0022});
        cyc();
        chk("rerun_ack", {a_ack, a_rdata}, {1'b1, ref_mem[key(0, 16'h0022)]});
        held_a = ref_mem[key(0, 16'h0022)];
        a_req = 0; last_b = 0;
        cyc();

        // Continuous tie after reset: round-robin vs fixed priority
        rst = 1; a_req = 1; b_req = 1; a_addr = 16'h0030;
        b_we = 0; b_region = 0; b_addr = 16'h0031;
        cyc();
        rst = 0; held_a = 0; held_b = 0;
        for (int j = 1; j <= 12; j++) begin
            cyc();
            chk($sformatf("rr_tie_c%0d", j), {a_ack, b_ack},
                {(j == 2 || j == 8), (j == 5 || j == 11)});
            chk($sformatf("fp_tie_c%0d", j), {f_a_ack, f_b_ack}, {1'b0, (j % 3 == 2)});
            if (j == 2) chk("rr_tie_a_rdata", a_rdata, ref_mem[key(0, 16'h0030)]);
            if (j == 5) chk("rr_tie_b_rdata", b_rdata, ref_mem[key(0, 16'h0031)]);
        end
        b_req = 0;
        for (int j = 13; j <= 15; j++) begin
            cyc();
            chk($sformatf("rr_drop_c%0d", j), {a_ack, b_ack}, {(j == 14), 1'b0});
            chk($sformatf("fp_drop_c%0d", j), {f_a_ack, f_b_ack}, {(j == 14), 1'b0});
            if (j == 14) a_req = 0;
        end
        last_b = 0;
        held_a = ref_mem[key(0, 16'h0030)];
        held_b = ref_mem[key(0, 16'h0031)];

        // Random traffic against the transaction-level model
        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(1, 3));
            ra = mode[0]; rb = mode[1];
            a_addr   = 16'($urandom_range(0, 63));
            b_we     = 1'($urandom_range(0, 1));
            b_region = 1'($urandom_range(0, 1));
            b_addr   = 16'($urandom_range(0, 63));
            b_wdata  = 16'($urandom);
            a_req = ra; b_req = rb;
            first_b = (ra && rb) ? !last_b : rb;
            n_cyc = (ra && rb) ? 5 : 2;
            for (int j = 1; j <= n_cyc; j++) begin
                cyc();
                exp_a = ra && ((!first_b && j == 2) || (first_b && j == 5));
                exp_b = rb && ((first_b && j == 2) || (!first_b && j == 5));
                chk($sformatf("rnd%0d_acks_c%0d", t, j), {a_ack, b_ack}, {exp_a, exp_b});
                if (j == 1)
                    chk($sformatf("rnd%0d_issue", t), {mem_e, mem_we}, {1'b1, first_b && b_we});
                if (exp_a) begin
                    held_a = ref_mem[key(0, a_addr)];
                    chk($sformatf("rnd%0d_a_rdata", t), a_rdata, held_a);
                    a_req = 0; last_b = 0;
                end
                if (exp_b) begin
                    if (b_we) begin
                        ref_mem[key(b_region, b_addr)] = b_wdata;
                    end else begin
                        held_b = ref_mem[key(b_region, b_addr)];
                        chk($sformatf("rnd%0d_b_rdata", t), b_rdata, held_b);
                    end
                    b_req = 0; last_b = 1;
                end
            end
            cyc();
            chk($sformatf("rnd%0d_idle", t), {busy, a_ack, b_ack, mem_e}, 4'b0000);
            chk($sformatf("rnd%0d_held", t), {a_rdata, b_rdata}, {held_a, held_b});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
